// File: rtl/stack_cpu_p_if.sv
// rtl/stack_cpu_p_if.sv - memory and ALU bus bundle for the stack_cpu_p core
// Ports (master = core side):
//   instruction / address_memory_inst / read_inst_enable : instruction fetch
//   memory_data_in / memory_data_out / address_memory_data /
//   read_data_enable / write_data_enable                  : data memory
//   operand_a / operand_b / op_alu / result_alu          : external combinational ALU
interface stack_cpu_p_if #(
  parameter int WIDTH_DATA = 32,
  parameter int AWIDTH     = 5,
  parameter int DAWIDTH    = 10
);
  logic [WIDTH_DATA-1:0] instruction;
  logic [AWIDTH-1:0]     address_memory_inst;
  logic                  read_inst_enable;
  logic [WIDTH_DATA-1:0] memory_data_in;
  logic [WIDTH_DATA-1:0] memory_data_out;
  logic [DAWIDTH-1:0]    address_memory_data;
  logic                  read_data_enable;
  logic                  write_data_enable;
  logic [WIDTH_DATA-1:0] operand_a;
  logic [WIDTH_DATA-1:0] operand_b;
  logic [3:0]            op_alu;
  logic [WIDTH_DATA-1:0] result_alu;

  modport master (
    input  instruction, memory_data_in, result_alu,
    output address_memory_inst, read_inst_enable,
    output memory_data_out, address_memory_data, read_data_enable, write_data_enable,
    output operand_a, operand_b, op_alu
  );

  modport slave (
    output instruction, memory_data_in, result_alu,
    input  address_memory_inst, read_inst_enable,
    input  memory_data_out, address_memory_data, read_data_enable, write_data_enable,
    input  operand_a, operand_b, op_alu
  );
endinterface

// File: rtl/stack_cpu_p.sv
// rtl/stack_cpu_p.sv - multi-cycle stack processor with operand and call stacks
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   bus        : stack_cpu_p_if.master (fetch, data memory, external ALU)
//   halted     : stopped by HALT
//   error      : stopped by a fault; error_code gives the cause (1..5)
//   depth      : operand stack occupancy
module stack_cpu_p #(
  parameter int WIDTH_DATA  = 32,
  parameter int AWIDTH      = 5,
  parameter int DAWIDTH     = 10,
  parameter int STACK_DEPTH = 16,
  parameter int CALL_DEPTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  stack_cpu_p_if.master                  bus,
  output logic                           halted,
  output logic                           error,
  output logic [2:0]                     error_code,
  output logic [$clog2(STACK_DEPTH):0]   depth
);
  localparam int OPW = WIDTH_DATA - 5;
  localparam int SW  = $clog2(STACK_DEPTH);
  localparam int CW  = (CALL_DEPTH > 1) ? $clog2(CALL_DEPTH) : 1;

  localparam logic [SW:0] STK_FULL  = (SW+1)'(STACK_DEPTH);
  localparam logic [SW:0] STK_TWO   = (SW+1)'(2);
  localparam logic [CW:0] CALL_FULL = (CW+1)'(CALL_DEPTH);

  localparam logic [4:0] OP_PUSH   = 5'd0;
  localparam logic [4:0] OP_PUSH_I = 5'd1;
  localparam logic [4:0] OP_PUSH_T = 5'd2;
  localparam logic [4:0] OP_POP    = 5'd3;
  localparam logic [4:0] OP_ADD    = 5'd4;
  localparam logic [4:0] OP_CMP    = 5'd12;
  localparam logic [4:0] OP_NOT    = 5'd13;
  localparam logic [4:0] OP_GOTO   = 5'd14;
  localparam logic [4:0] OP_IF_EQ  = 5'd15;
  localparam logic [4:0] OP_IF_GT  = 5'd16;
  localparam logic [4:0] OP_IF_LT  = 5'd17;
  localparam logic [4:0] OP_IF_GE  = 5'd18;
  localparam logic [4:0] OP_IF_LE  = 5'd19;
  localparam logic [4:0] OP_CALL   = 5'd20;
  localparam logic [4:0] OP_RET    = 5'd21;
  localparam logic [4:0] OP_HALT   = 5'd22;

  typedef enum logic [2:0] {
    S_FETCH, S_WAIT_INST, S_EXEC, S_MEM_RD, S_ALU_WB, S_HALTED, S_ERROR
  } state_t;

  state_t                state;
  logic [AWIDTH-1:0]     pc;
  logic [WIDTH_DATA-1:0] ir;
  logic [WIDTH_DATA-1:0] temp;
  logic [CW:0]           cdepth;

  // Stack storage carries no reset: occupancy counters define what is valid.
  logic [WIDTH_DATA-1:0] stk  [STACK_DEPTH];
  logic [AWIDTH-1:0]     cstk [CALL_DEPTH];

  logic [4:0]            opcode;
  logic [OPW-1:0]        operand;
  logic [SW-1:0]         tos_idx, nos_idx, push_idx;
  logic [CW-1:0]         ctop_idx, cpush_idx;
  logic [WIDTH_DATA-1:0] tos, nos;
  logic [AWIDTH-1:0]     pc_inc, target;
  logic                  is_push, is_bin, is_not, is_if, is_alu, illegal;
  logic                  fault, taken, tos_zero, tos_neg;
  logic [2:0]            fault_code;
  logic                  stk_we;
  logic [SW-1:0]         stk_widx;
  logic [WIDTH_DATA-1:0] stk_wdata;
  logic                  cstk_we;
  logic                  rd_d, wr_d, alu_active;

  assign opcode    = ir[WIDTH_DATA-1 -: 5];
  assign operand   = ir[OPW-1:0];
  assign target    = operand[AWIDTH-1:0];
  assign pc_inc    = pc + 1'b1;  // wraps modulo 2^AWIDTH
  assign tos_idx   = SW'(depth - 1'b1);
  assign nos_idx   = SW'(depth - 2'd2);
  assign push_idx  = SW'(depth);
  assign ctop_idx  = CW'(cdepth - 1'b1);
  assign cpush_idx = CW'(cdepth);
  assign tos       = stk[tos_idx];
  assign nos       = stk[nos_idx];
  assign tos_zero  = (tos == '0);
  assign tos_neg   = tos[WIDTH_DATA-1];

  assign is_push = (opcode == OP_PUSH) || (opcode == OP_PUSH_I) || (opcode == OP_PUSH_T);
  assign is_bin  = (opcode >= OP_ADD) && (opcode <= OP_CMP);
  assign is_not  = (opcode == OP_NOT);
  assign is_alu  = is_bin || is_not;
  assign is_if   = (opcode >= OP_IF_EQ) && (opcode <= OP_IF_LE);
  assign illegal = (opcode > OP_HALT);

  // Fault decode runs ahead of every side effect of EXEC.
  always_comb begin
    fault_code = 3'd0;
    if (illegal)                                                     fault_code = 3'd5;
    else if (is_push && depth == STK_FULL)                           fault_code = 3'd1;
    else if ((opcode == OP_POP || is_if || is_not) && depth == '0)   fault_code = 3'd2;
    else if (is_bin && depth < STK_TWO)                              fault_code = 3'd2;
    else if (opcode == OP_CALL && cdepth == CALL_FULL)               fault_code = 3'd3;
    else if (opcode == OP_RET && cdepth == '0)                       fault_code = 3'd4;
  end
  assign fault = (fault_code != 3'd0);

  // Signed comparison of TOS against zero, using only sign and zero flags.
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_IF_EQ: taken = tos_zero;
      OP_IF_GT: taken = !tos_neg && !tos_zero;
      OP_IF_LT: taken = tos_neg;
      OP_IF_GE: taken = !tos_neg;
      OP_IF_LE: taken = tos_neg || tos_zero;
      default:  taken = 1'b0;
    endcase
  end

  // Bus outputs decode from state; the fetch strobe is gated by rst so that
  // nothing is issued while reset is held even though the state is FETCH.
  assign rd_d       = (state == S_EXEC) && (opcode == OP_PUSH) && !fault;
  assign wr_d       = (state == S_EXEC) && (opcode == OP_POP) && !fault;
  assign alu_active = ((state == S_EXEC) && is_alu && !fault) || (state == S_ALU_WB);

  always_comb begin
    bus.address_memory_inst = pc;
    bus.read_inst_enable    = rst && (state == S_FETCH);
    bus.read_data_enable    = rd_d;
    bus.write_data_enable   = wr_d;
    bus.address_memory_data = (rd_d || wr_d) ? operand[DAWIDTH-1:0] : '0;
    bus.memory_data_out     = wr_d ? tos : '0;
    // Operands stay driven through ALU_WB because result_alu is combinational.
    bus.operand_a           = alu_active ? tos : '0;
    bus.operand_b           = alu_active ? nos : '0;
    bus.op_alu              = alu_active ? (opcode[3:0] - 4'd4) : 4'd0;
  end

  always_comb begin
    stk_we    = 1'b0;
    stk_widx  = push_idx;
    stk_wdata = '0;
    if (state == S_EXEC && !fault) begin
      if (opcode == OP_PUSH_I) begin
        stk_we    = 1'b1;
        stk_wdata = {5'd0, operand};
      end else if (opcode == OP_PUSH_T) begin
        stk_we    = 1'b1;
        stk_wdata = temp;
      end
    end else if (state == S_MEM_RD) begin
      stk_we    = 1'b1;
      stk_wdata = bus.memory_data_in;
    end else if (state == S_ALU_WB) begin
      // Binary result lands in the NOS slot; depth drops by one below.
      stk_we    = 1'b1;
      stk_widx  = is_bin ? nos_idx : tos_idx;
      stk_wdata = bus.result_alu;
    end
  end

  assign cstk_we = (state == S_EXEC) && !fault && (opcode == OP_CALL);

  always_ff @(posedge clk) begin
    if (stk_we)  stk[stk_widx]   <= stk_wdata;
    if (cstk_we) cstk[cpush_idx] <= pc_inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_FETCH;
      pc         <= '0;
      ir         <= '0;
      temp       <= '0;
      depth      <= '0;
      cdepth     <= '0;
      halted     <= 1'b0;
      error      <= 1'b0;
      error_code <= 3'd0;
    end else begin
      case (state)
        S_FETCH:     state <= S_WAIT_INST;
        S_WAIT_INST: begin
          ir    <= bus.instruction;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (fault) begin
            error      <= 1'b1;
            error_code <= fault_code;
            state      <= S_ERROR;
          end else if (opcode == OP_PUSH) begin
            state <= S_MEM_RD;
          end else if (opcode == OP_PUSH_I || opcode == OP_PUSH_T) begin
            depth <= depth + 1'b1;
            pc    <= pc_inc;
            state <= S_FETCH;
          end else if (opcode == OP_POP) begin
            temp  <= tos;
            depth <= depth - 1'b1;
            pc    <= pc_inc;
            state <= S_FETCH;
          end else if (is_alu) begin
            state <= S_ALU_WB;
          end else if (opcode == OP_GOTO) begin
            pc    <= target;
            state <= S_FETCH;
          end else if (is_if) begin
            depth <= depth - 1'b1;
            pc    <= taken ? target : pc_inc;
            state <= S_FETCH;
          end else if (opcode == OP_CALL) begin
            cdepth <= cdepth + 1'b1;
            pc     <= target;
            state  <= S_FETCH;
          end else if (opcode == OP_RET) begin
            cdepth <= cdepth - 1'b1;
            pc     <= cstk[ctop_idx];
            state  <= S_FETCH;
          end else begin
            halted <= 1'b1;
            state  <= S_HALTED;
          end
        end
        S_MEM_RD: begin
          depth <= depth + 1'b1;
          pc    <= pc_inc;
          state <= S_FETCH;
        end
        S_ALU_WB: begin
          if (is_bin) depth <= depth - 1'b1;
          pc    <= pc_inc;
          state <= S_FETCH;
        end
        S_HALTED: state <= S_HALTED;
        S_ERROR:  state <= S_ERROR;
        default:  state <= S_ERROR;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_cpu_p.sv
// tb/tb_stack_cpu_p.sv - directed self-checking bench for stack_cpu_p
module tb_stack_cpu_p;
  localparam logic [4:0] OP_PUSH = 5'd0,  OP_PUSH_I = 5'd1, OP_PUSH_T = 5'd2, OP_POP = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4,  OP_SUB = 5'd5,    OP_NOT = 5'd13,   OP_GOTO = 5'd14;
  localparam logic [4:0] OP_IF_LT = 5'd17, OP_CALL = 5'd20, OP_RET = 5'd21,   OP_HALT = 5'd22;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       halted, error;
  logic [2:0] error_code;
  logic [4:0] depth;

  logic [31:0] imem [32];
  logic [31:0] dmem [1024];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int quiet;
  logic both_seen = 1'b0;

  stack_cpu_p_if bus_if ();

  stack_cpu_p dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .halted     (halted),
    .error      (error),
    .error_code (error_code),
    .depth      (depth)
  );

  always #5 clk = ~clk;

  // Synchronous instruction/data memories: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (bus_if.read_inst_enable)  bus_if.instruction    <= imem[bus_if.address_memory_inst];
    if (bus_if.read_data_enable)  bus_if.memory_data_in <= dmem[bus_if.address_memory_data];
    if (bus_if.write_data_enable) dmem[bus_if.address_memory_data] <= bus_if.memory_data_out;
  end

  // ALU model: a is TOS, b is next-on-stack.
  always_comb begin
    case (bus_if.op_alu)
      4'd0:    bus_if.result_alu = bus_if.operand_a + bus_if.operand_b;
      4'd1:    bus_if.result_alu = bus_if.operand_a - bus_if.operand_b;
      4'd9:    bus_if.result_alu = ~bus_if.operand_a;
      default: bus_if.result_alu = bus_if.operand_a;
    endcase
  end

  always @(negedge clk)
    if (bus_if.read_data_enable && bus_if.write_data_enable) both_seen = 1'b1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input int unsigned arg);
    logic [31:0] a;
    a = arg;
    return {op, a[26:0]};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 32; i++) imem[i] = enc(OP_HALT, 0);
  endtask

  task automatic start_prog();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_to_stop(input int max);
    cyc = 0;
    while (!(halted || error) && cyc < max) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stop_within_bound", {62'd0, halted, error} != 0, 1);
  endtask

  initial begin
    // Reset state while rst is held low.
    repeat (2) @(negedge clk);
    check("rst_read_inst_enable", bus_if.read_inst_enable, 0);
    check("rst_pc", bus_if.address_memory_inst, 0);
    check("rst_depth", depth, 0);
    check("rst_status", {halted, error, error_code}, 0);
    check("rst_data_strobes", {bus_if.read_data_enable, bus_if.write_data_enable}, 0);

    // PUSH_I 5; PUSH_I 3; SUB; POP 7; HALT -> 3-5 stored at 7, halted on cycle 16.
    clear_imem();
    imem[0] = enc(OP_PUSH_I, 5);
    imem[1] = enc(OP_PUSH_I, 3);
    imem[2] = enc(OP_SUB, 0);
    imem[3] = enc(OP_POP, 7);
    imem[4] = enc(OP_HALT, 0);
    start_prog();
    #1 check("first_fetch_addr", {bus_if.read_inst_enable, bus_if.address_memory_inst}, {1'b1, 5'd0});
    repeat (15) @(posedge clk);
    #1 check("halted_cycle15", halted, 0);
    @(posedge clk); #1;
    check("halted_cycle16", halted, 1);
    check("sub_result_mem7", dmem[7], 32'hFFFF_FFFE);
    check("prog1_depth", depth, 0);
    check("prog1_error", error, 0);
    quiet = 0;
    repeat (4) begin
      @(posedge clk); #1;
      quiet += int'(bus_if.read_inst_enable) + int'(bus_if.read_data_enable) + int'(bus_if.write_data_enable);
    end
    check("halted_no_strobes", quiet, 0);

    // Reset clears temp: PUSH_T pushes 0 over the earlier value at 7.
    clear_imem();
    imem[0] = enc(OP_PUSH_T, 0);
    imem[1] = enc(OP_POP, 7);
    start_prog();
    run_to_stop(100);
    check("push_t_after_reset", dmem[7], 0);

    // STACK_DEPTH+1 pushes overflow.
    clear_imem();
    for (int i = 0; i < 17; i++) imem[i] = enc(OP_PUSH_I, i + 1);
    start_prog();
    run_to_stop(300);
    check("ovf_code", {error, error_code}, {1'b1, 3'd1});
    check("ovf_depth", depth, 16);
    check("ovf_pc_held", bus_if.address_memory_inst, 16);
    quiet = 0;
    repeat (6) begin
      @(posedge clk); #1;
      quiet += int'(bus_if.read_inst_enable) + int'(bus_if.read_data_enable) + int'(bus_if.write_data_enable);
    end
    check("error_no_strobes", quiet, 0);

    // ADD on empty stack underflows.
    clear_imem();
    imem[0] = enc(OP_ADD, 0);
    start_prog();
    run_to_stop(50);
    check("add_empty_code", {error, error_code}, {1'b1, 3'd2});
    check("add_empty_depth", depth, 0);

    // IF_LT taken on -1 (0-1 via SUB); not taken on all-ones PUSH_I (zero-extended, positive).
    clear_imem();
    imem[0]  = enc(OP_PUSH_I, 1);
    imem[1]  = enc(OP_PUSH_I, 0);
    imem[2]  = enc(OP_SUB, 0);
    imem[3]  = enc(OP_IF_LT, 9);
    imem[9]  = enc(OP_PUSH_I, 32'h07FF_FFFF);
    imem[10] = enc(OP_IF_LT, 20);
    start_prog();
    run_to_stop(200);
    check("if_lt_path_pc", {halted, bus_if.address_memory_inst}, {1'b1, 5'd11});
    check("if_lt_depth", depth, 0);

    // GOTO 3; CALL 10 at 3; RET at 10 -> 4; then PUSH/POP memory round trip; NOT.
    clear_imem();
    imem[0]  = enc(OP_GOTO, 3);
    imem[3]  = enc(OP_CALL, 10);
    imem[4]  = enc(OP_PUSH_I, 9);
    imem[5]  = enc(OP_POP, 20);
    imem[6]  = enc(OP_PUSH, 20);
    imem[7]  = enc(OP_NOT, 0);
    imem[8]  = enc(OP_POP, 21);
    imem[10] = enc(OP_RET, 0);
    start_prog();
    run_to_stop(300);
    check("call_ret_halt_pc", {halted, error, bus_if.address_memory_inst}, {1'b1, 1'b0, 5'd9});
    check("push_not_pop_mem21", dmem[21], 32'hFFFF_FFF6);
    check("call_ret_depth", depth, 0);

    // CALL_DEPTH+1 nested calls.
    clear_imem();
    for (int i = 0; i < 9; i++) imem[i] = enc(OP_CALL, i + 1);
    start_prog();
    run_to_stop(300);
    check("call_ovf_code", {error, error_code, bus_if.address_memory_inst}, {1'b1, 3'd3, 5'd8});

    // RET with empty call stack.
    clear_imem();
    imem[0] = enc(OP_RET, 0);
    start_prog();
    run_to_stop(50);
    check("ret_empty_code", {error, error_code}, {1'b1, 3'd4});

    // Asynchronous reset during MEM_RD of a PUSH.
    clear_imem();
    imem[0] = enc(OP_PUSH_I, 4);
    imem[1] = enc(OP_PUSH, 5);
    start_prog();
    repeat (5) @(posedge clk);
    #1 check("push_rd_strobe", {bus_if.read_data_enable, bus_if.address_memory_data}, {1'b1, 10'd5});
    @(posedge clk); #1;
    check("mem_rd_pre_reset", {depth, bus_if.address_memory_inst}, {5'd1, 5'd1});
    #2 rst = 1'b0;
    #1 check("async_rst_depth_pc", {depth, bus_if.address_memory_inst}, 0);
    check("async_rst_strobes", {bus_if.read_inst_enable, bus_if.read_data_enable, bus_if.write_data_enable}, 0);
    @(negedge clk) rst = 1'b1;
    #1 check("refetch_addr0", {bus_if.read_inst_enable, bus_if.address_memory_inst}, {1'b1, 5'd0});
    repeat (3) @(posedge clk);
    #1 check("refetch_push_i", depth, 1);

    // GOTO 31 holding PUSH_I: PC wraps to 0.
    clear_imem();
    imem[0]  = enc(OP_GOTO, 31);
    imem[31] = enc(OP_PUSH_I, 6);
    start_prog();
    repeat (3) @(posedge clk);
    #1 check("goto_31", bus_if.address_memory_inst, 31);
    repeat (3) @(posedge clk);
    #1 check("pc_wrap_fetch0", {bus_if.read_inst_enable, bus_if.address_memory_inst, depth}, {1'b1, 5'd0, 5'd1});

    // Illegal opcode.
    clear_imem();
    imem[0] = enc(5'd25, 0);
    start_prog();
    run_to_stop(50);
    check("illegal_code", {error, error_code}, {1'b1, 3'd5});

    check("rd_wr_never_together", both_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
